// File: rtl/imuldiv_muldiv_dispatch.sv
// Mul/div request dispatcher: decodes the function code, issues to the
// multiplier or divider, and returns responses in acceptance order.
module imuldiv_muldiv_dispatch #(
  parameter int unsigned ORDER_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,

  output logic [63:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy,

  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,

  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,

  output logic        divreq_msg_signed,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,

  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy
);

  localparam int unsigned PW       = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(ORDER_DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {
    KIND_MUL,
    KIND_DIVQ,
    KIND_DIVR,
    KIND_ERR
  } kind_e;

  kind_e       order_q [ORDER_DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] count;

  kind_e req_kind;
  kind_e head_kind;
  logic  is_mul;
  logic  is_div;
  logic  target_rdy;
  logic  full;
  logic  empty;
  logic  issue_en;
  logic  push;
  logic  pop;

  // Decode the function code into the order-FIFO tag and the target unit.
  always_comb begin
    req_kind   = KIND_ERR;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    target_rdy = 1'b1;
    unique case (muldivreq_msg_fn)
      FN_MUL: begin
        req_kind   = KIND_MUL;
        is_mul     = 1'b1;
        target_rdy = mulreq_rdy;
      end
      FN_DIV, FN_DIVU: begin
        req_kind   = KIND_DIVQ;
        is_div     = 1'b1;
        target_rdy = divreq_rdy;
      end
      FN_REM, FN_REMU: begin
        req_kind   = KIND_DIVR;
        is_div     = 1'b1;
        target_rdy = divreq_rdy;
      end
      default: ;
    endcase
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Request side is held off while reset is asserted: an empty FIFO alone
  // would otherwise leave muldivreq_rdy and the unit valids free to rise.
  assign issue_en      = reset && !full;
  assign muldivreq_rdy = issue_en && target_rdy;
  assign mulreq_val    = muldivreq_val && is_mul && issue_en;
  assign divreq_val    = muldivreq_val && is_div && issue_en;

  assign mulreq_msg_a      = muldivreq_msg_a;
  assign mulreq_msg_b      = muldivreq_msg_b;
  assign divreq_msg_a      = muldivreq_msg_a;
  assign divreq_msg_b      = muldivreq_msg_b;
  assign divreq_msg_signed = (muldivreq_msg_fn == FN_DIV) || (muldivreq_msg_fn == FN_REM);

  assign push      = muldivreq_val && muldivreq_rdy;
  assign head_kind = order_q[rd_ptr[PW-1:0]];

  // Steer the response port to whichever unit owns the oldest request.
  always_comb begin
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = '0;
    mulresp_rdy           = 1'b0;
    divresp_rdy           = 1'b0;
    if (!empty) begin
      unique case (head_kind)
        KIND_MUL: begin
          muldivresp_val        = mulresp_val;
          muldivresp_msg_result = mulresp_msg_result;
          mulresp_rdy           = muldivresp_rdy;
        end
        KIND_DIVQ: begin
          muldivresp_val        = divresp_val;
          muldivresp_msg_result = {32'b0, divresp_msg_result[31:0]};
          divresp_rdy           = muldivresp_rdy;
        end
        KIND_DIVR: begin
          muldivresp_val        = divresp_val;
          muldivresp_msg_result = {32'b0, divresp_msg_result[63:32]};
          divresp_rdy           = muldivresp_rdy;
        end
        default: begin
          muldivresp_val        = 1'b1;
          muldivresp_msg_result = '1;
        end
      endcase
    end
  end

  assign pop = muldivresp_val && muldivresp_rdy;

  // Order-FIFO storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push) order_q[wr_ptr[PW-1:0]] <= req_kind;
  end

  // Pointers and occupancy; pointers wrap naturally on their low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
Name: imuldiv_muldiv_dispatch

Overview:
Front-end for the integer mul/div subsystem. Decodes a function-tagged request and issues it to the iterative multiplier or the iterative divider. Records issue order in a small order FIFO, then returns the two units' responses in request order on one val/rdy response port. Sits directly upstream of the multiplier's mulreq port and consumes its mulresp port.

Parameters:
ORDER_DEPTH, 2, order-FIFO entries, i.e. max requests in flight; power of two, >=2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
muldivreq_msg_fn  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU, 5-7 illegal
muldivreq_msg_a  in  32  operand A
muldivreq_msg_b  in  32  operand B
muldivreq_val  in  1  request valid
muldivreq_rdy  out  1  request ready
muldivresp_msg_result  out  64  result
muldivresp_val  out  1  response valid
muldivresp_rdy  in  1  response ready
mulreq_msg_a / mulreq_msg_b  out  32 each  operands to multiplier
mulreq_val  out  1
mulreq_rdy  in  1
mulresp_msg_result  in  64  signed 64-bit product
mulresp_val  in  1
mulresp_rdy  out  1
divreq_msg_signed  out  1  1 for DIV/REM
divreq_msg_a / divreq_msg_b  out  32 each
divreq_val  out  1
divreq_rdy  in  1
divresp_msg_result  in  64  {remainder[31:0], quotient[31:0]}
divresp_val  in  1
divresp_rdy  out  1

Behaviour:
- State: order FIFO of ORDER_DEPTH entries, each holding kind (MUL, DIVQ, DIVR, ERR). Write pointer, read pointer and occupancy count are log2(ORDER_DEPTH)+1 bits wide.
- Reset (reset=0, async): pointers and count = 0. All *_val outputs = 0, muldivreq_rdy = 0, mulresp_rdy = divresp_rdy = 0, muldivresp_msg_result = 0.
- Operands pass through combinationally to both units. mulreq_val and divreq_val are gated by decode, so only the target unit sees val=1. divreq_msg_signed = (fn==DIV || fn==REM).
- Request ready:
  - muldivreq_rdy = !full && target_rdy.
  - target_rdy is mulreq_rdy for MUL, divreq_rdy for DIV/DIVU/REM/REMU, and 1 for illegal fn.
  - Unit val is asserted only when !full.
- Accept: muldivreq_val && muldivreq_rdy. On the same edge the unit sees val&&rdy and an entry is pushed:
  - MUL -> MUL; DIV/DIVU -> DIVQ; REM/REMU -> DIVR; fn 5-7 -> ERR.
  - No unit is issued for ERR.
- Head selection (FIFO non-empty):
  - MUL: muldivresp_val = mulresp_val; mulresp_rdy = muldivresp_rdy; result = mulresp_msg_result.
  - DIVQ: muldivresp_val = divresp_val; divresp_rdy = muldivresp_rdy; result = {32'b0, quotient}.
  - DIVR: as DIVQ; result = {32'b0, remainder}.
  - ERR: muldivresp_val = 1; result = 64'hFFFF_FFFF_FFFF_FFFF.
  - The non-head unit's resp_rdy = 0. Any response it holds waits.
- Empty FIFO: muldivresp_val = 0, both unit resp_rdy = 0, result = 0.
- Pop on muldivresp_val && muldivresp_rdy.
- Full FIFO: muldivreq_rdy = 0 even if a pop occurs in the same cycle (no bypass). Push and pop in the same cycle when not full leaves count unchanged.
- Pointers wrap modulo ORDER_DEPTH.
- Latency: request-to-unit is 0 cycles. An ERR response is visible 1 cycle after acceptance. Dispatcher adds 0 cycles to unit response latency.
- Ordering: responses leave in acceptance order, even when the later unit finishes first.
- Reset mid-operation: FIFO is cleared. Responses still held by the units are never acknowledged by this block; the units are reset by the same signal.

Test Plan:
- MUL a=-3, b=7, unit rdy/resp immediate -> one cycle later muldivresp_msg_result=64'hFFFF_FFFF_FFFF_FFEB, muldivresp_val=1, mulreq_val seen exactly once.
- DIV a=-7, b=2 then REMU a=7, b=2 back-to-back -> results 64'h0000_0000_FFFF_FFFD then 64'h1. divreq_msg_signed=1 then 0.
- MUL issued, then DIV issued; divider responds 5 cycles before multiplier -> muldivresp emits the MUL result first. divresp_rdy stays 0 until the MUL pops.
- fn=6 -> no mulreq_val/divreq_val pulse. Next cycle result=all-ones, val=1. Holding muldivresp_rdy=0 for 4 cycles keeps val and result stable.
- Issue 2 requests with muldivresp_rdy=0 -> muldivreq_rdy=0 with a third valid request present. Asserting resp_rdy for one cycle pops one, and muldivreq_rdy returns the following cycle.
- Drive reset=0 asynchronously mid-cycle with 2 entries in flight -> outputs go to reset values immediately without a clock edge. After release, a fresh MUL 2*3 returns 64'h6.
